// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader for the CPU's byte-wide instruction memory.
// Frame: len_lo, len_hi, N payload bytes, 8-bit additive checksum; CPU reset released on success.
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              word_valid,
  output logic [31:0]       word_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0]       MAX_N = 17'(MAX_BYTES);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t      state_reg;
  logic [7:0]  len_lo_reg;
  logic [15:0] len_reg;
  logic [15:0] cnt_reg;
  logic [7:0]  sum_reg;

  logic        fire;
  logic        data_fire;
  logic        last_byte;
  logic [15:0] len_next;
  logic        len_bad;

  assign fire      = in_valid && in_ready;
  assign data_fire = fire && (state_reg == DATA);
  assign last_byte = (cnt_reg + 16'd1) == len_reg;
  assign len_next  = {in_data, len_lo_reg};
  // Payload must fit the memory window and be a whole number of 32-bit words.
  assign len_bad   = ({1'b0, len_next} > MAX_N) || (len_next[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= HDR0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= 8'h00;
      word_valid <= 1'b0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      len_lo_reg <= 8'h00;
      len_reg    <= 16'h0000;
      cnt_reg    <= 16'h0000;
      sum_reg    <= 8'h00;
    end else begin
      mem_we     <= 1'b0;
      word_valid <= 1'b0;
      case (state_reg)
        HDR0: begin
          in_ready <= 1'b1;
          if (fire) begin
            len_lo_reg <= in_data;
            state_reg  <= HDR1;
          end
        end
        HDR1: begin
          if (fire) begin
            len_reg <= len_next;
            cnt_reg <= 16'h0000;
            sum_reg <= 8'h00;
            if (len_bad) begin
              state_reg <= ERR;
              in_ready  <= 1'b0;
              error     <= 1'b1;
            end else if (len_next == 16'h0000) begin
              state_reg <= CSUM;
            end else begin
              state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (fire) begin
            mem_we     <= 1'b1;
            mem_wdata  <= in_data;
            mem_addr   <= BASE + ADDR_W'(cnt_reg);
            word_valid <= (cnt_reg[1:0] == 2'd3);
            cnt_reg    <= cnt_reg + 16'd1;
            sum_reg    <= sum_reg + in_data;
            if (last_byte) begin
              state_reg <= CSUM;
            end
          end
        end
        CSUM: begin
          if (fire) begin
            in_ready <= 1'b0;
            if (in_data == sum_reg) begin
              state_reg <= DONE;
              done      <= 1'b1;
              cpu_rst   <= 1'b0;
            end else begin
              state_reg <= ERR;
              error     <= 1'b1;
            end
          end
        end
        DONE: begin
          in_ready <= 1'b0;
        end
        ERR: begin
          in_ready <= 1'b0;
        end
        default: begin
          // Unreachable encodings fail safe: hold the CPU in reset.
          state_reg <= ERR;
          in_ready  <= 1'b0;
          error     <= 1'b1;
          cpu_rst   <= 1'b1;
        end
      endcase
    end
  end

  // One byte lane per word position; lane k captures payload bytes with index mod 4 == k.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_reg <= 8'h00;
      end else if (data_fire && (cnt_reg[1:0] == 2'(gi))) begin
        lane_reg <= in_data;
      end
    end

    assign word_data[8*gi +: 8] = lane_reg;
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus random frames on two
// instances (default window, and BASE_ADDR=16 / MAX_BYTES=8) against a frame-level model.
module tb_imem_boot_loader;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst        [2];
  logic          in_valid   [2];
  logic [7:0]    in_data    [2];
  logic          in_ready   [2];
  logic          mem_we     [2];
  logic [AW-1:0] mem_addr   [2];
  logic [7:0]    mem_wdata  [2];
  logic          word_valid [2];
  logic [31:0]   word_data  [2];
  logic          cpu_rst    [2];
  logic          done       [2];
  logic          error      [2];

  int base_of [2] = '{0, 16};
  int max_of  [2] = '{1024, 8};

  int checks = 0;
  int errors = 0;

  logic [7:0] frame_q[$];

  imem_boot_loader #(.ADDR_W(AW)) u0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .word_valid(word_valid[0]), .word_data(word_data[0]),
    .cpu_rst(cpu_rst[0]), .done(done[0]), .error(error[0])
  );

  imem_boot_loader #(.ADDR_W(AW), .BASE_ADDR(16), .MAX_BYTES(8)) u1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .word_valid(word_valid[1]), .word_data(word_data[1]),
    .cpu_rst(cpu_rst[1]), .done(done[1]), .error(error[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int s);
    logic [63:0] obs;
    logic [63:0] exp;
    rst[s]      = 1'b1;
    in_valid[s] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    obs = {8'h00, in_ready[s], mem_we[s], mem_addr[s], mem_wdata[s], word_valid[s],
           word_data[s], cpu_rst[s], done[s], error[s]};
    exp = {8'h00, 1'b0, 1'b0, AW'(base_of[s]), 8'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    check($sformatf("reset_values[u%0d]", s), obs, exp);
    rst[s] = 1'b0;
  endtask

  task automatic make_frame(input int lenfield, input int npay, input bit bad);
    logic [7:0] sum;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(lenfield));
    frame_q.push_back(8'(lenfield >> 8));
    sum = 8'h00;
    for (int i = 0; i < npay; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      sum = sum + b;
    end
    frame_q.push_back(bad ? sum + 8'h01 : sum);
  endtask

  // mode 0: in_valid held high; 1: pattern 1,0,0,...; 2: random in_valid.
  task automatic run_frame(input int s, input int mode, input string name);
    int          n;
    bit          hdr_err;
    int          consume;
    int          exp_addr[$];
    logic [7:0]  exp_data[$];
    logic [31:0] exp_word[$];
    logic [7:0]  sum;
    bit          exp_done;
    int          w_addr[$];
    logic [7:0]  w_data[$];
    int          w_cyc[$];
    logic [31:0] wd[$];
    int          wd_cyc[$];
    int          fire_cyc[$];
    int          idx;
    int          cyc;
    int          limit;
    bit          v;

    // Frame-level model
    n       = int'(frame_q[1]) * 256 + int'(frame_q[0]);
    hdr_err = (n > max_of[s]) || (n % 4 != 0);
    consume = hdr_err ? 2 : n + 3;
    sum     = 8'h00;
    if (!hdr_err) begin
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(base_of[s] + i);
        exp_data.push_back(frame_q[2+i]);
        sum = sum + frame_q[2+i];
      end
      for (int w = 0; w < n / 4; w++) begin
        exp_word.push_back({frame_q[2+4*w+3], frame_q[2+4*w+2], frame_q[2+4*w+1], frame_q[2+4*w]});
      end
    end
    exp_done = !hdr_err && (sum == frame_q[2+n]);

    idx   = 0;
    cyc   = 0;
    limit = 20 * consume + 50;
    while (idx < consume && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (mem_we[s]) begin
        w_addr.push_back(int'(mem_addr[s]));
        w_data.push_back(mem_wdata[s]);
        w_cyc.push_back(cyc);
      end
      if (word_valid[s]) begin
        wd.push_back(word_data[s]);
        wd_cyc.push_back(cyc);
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 1);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      in_valid[s] = v;
      in_data[s]  = v ? frame_q[idx] : 8'($urandom);
      if (v && in_ready[s]) begin
        if (!hdr_err && idx >= 2 && idx < 2 + n) fire_cyc.push_back(cyc);
        idx++;
      end
    end
    check($sformatf("%s:bytes_consumed", name), idx, consume);

    // Keep offering junk: a finished loader must ignore it.
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      cyc++;
      if (mem_we[s]) begin
        w_addr.push_back(int'(mem_addr[s]));
        w_data.push_back(mem_wdata[s]);
        w_cyc.push_back(cyc);
      end
      if (word_valid[s]) begin
        wd.push_back(word_data[s]);
        wd_cyc.push_back(cyc);
      end
      if (t == 1) begin
        check($sformatf("%s:done_next_cycle", name), done[s], exp_done);
        check($sformatf("%s:error_next_cycle", name), error[s], !exp_done);
      end
      in_valid[s] = 1'b1;
      in_data[s]  = 8'($urandom);
    end
    in_valid[s] = 1'b0;

    check($sformatf("%s:done", name), done[s], exp_done);
    check($sformatf("%s:error", name), error[s], !exp_done);
    check($sformatf("%s:cpu_rst", name), cpu_rst[s], !exp_done);
    check($sformatf("%s:in_ready_after", name), in_ready[s], 1'b0);
    check($sformatf("%s:write_count", name), w_addr.size(), exp_addr.size());
    if (w_addr.size() == exp_addr.size()) begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        check($sformatf("%s:addr[%0d]", name, i), w_addr[i], exp_addr[i]);
        check($sformatf("%s:wdata[%0d]", name, i), w_data[i], exp_data[i]);
        check($sformatf("%s:wcycle[%0d]", name, i), w_cyc[i], fire_cyc[i] + 1);
      end
    end
    check($sformatf("%s:word_count", name), wd.size(), exp_word.size());
    if (wd.size() == exp_word.size() && w_cyc.size() == exp_addr.size()) begin
      for (int w = 0; w < exp_word.size(); w++) begin
        check($sformatf("%s:word[%0d]", name, w), wd[w], exp_word[w]);
        check($sformatf("%s:word_cycle[%0d]", name, w), wd_cyc[w], w_cyc[4*w+3]);
      end
    end
    $display("frame %s on u%0d: len=%0d consumed=%0d writes=%0d words=%0d done=%0b error=%0b",
             name, s, n, idx, w_addr.size(), wd.size(), done[s], error[s]);
  endtask

  initial begin
    int s;
    int n;
    int idx;
    int cyc;
    bit bad;

    for (int i = 0; i < 2; i++) begin
      rst[i]      = 1'b1;
      in_valid[i] = 1'b0;
      in_data[i]  = 8'h00;
    end
    do_reset(0);
    do_reset(1);

    frame_q = '{8'h04, 8'h00, 8'h05, 8'h00, 8'h01, 8'h24, 8'h2A};
    run_frame(0, 0, "single_word");
    do_reset(0);
    run_frame(0, 1, "bubbles");
    do_reset(0);
    frame_q[6] = 8'h2B;
    run_frame(0, 0, "bad_csum");

    do_reset(0);
    make_frame(6, 6, 1'b0);
    run_frame(0, 0, "len_6");
    do_reset(0);
    make_frame(16'h0404, 0, 1'b0);
    run_frame(0, 0, "len_0404");
    do_reset(0);
    make_frame(0, 0, 1'b0);
    run_frame(0, 0, "len_0");

    // Abort after two payload bytes, then a clean 8-byte load.
    do_reset(0);
    make_frame(8, 8, 1'b0);
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      in_valid[0] = 1'b1;
      in_data[0]  = frame_q[idx];
      if (in_ready[0]) idx++;
    end
    check("midload:bytes_sent", idx, 4);
    @(negedge clk);
    do_reset(0);
    make_frame(8, 8, 1'b0);
    run_frame(0, 2, "after_reset");

    do_reset(1);
    make_frame(8, 8, 1'b0);
    run_frame(1, 0, "base16_len8");
    do_reset(1);
    make_frame(12, 12, 1'b0);
    run_frame(1, 0, "base16_len12");

    for (int r = 0; r < 12; r++) begin
      s   = r % 2;
      bad = ($urandom_range(0, 3) == 0);
      if (s == 0) begin
        n = 4 * $urandom_range(0, 16);
        if (r % 4 == 2) n = n + $urandom_range(1, 3);
      end else begin
        n = 4 * $urandom_range(0, 3);
      end
      do_reset(s);
      make_frame(n, n, bad);
      run_frame(s, 2, $sformatf("random%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
